// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks an instruction through NUM_STAGES stages,
// runs the MFC/ANA memory handshake with a wait-state timeout, and latches faults.
module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int FETCH_STAGE = 1,
  parameter int MEM_STAGE   = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  Step_Mode,
  input  logic                  Step,
  input  logic                  Mem_Req,
  input  logic                  Mem_Write_Req,
  input  logic                  NOP,
  input  logic                  MEM_MFC,
  input  logic                  MEM_ANA_FLAG,
  output logic [3:0]            Stage,
  output logic [NUM_STAGES-1:0] Stage_Onehot,
  output logic                  Stage_Done,
  output logic                  MEM_Read,
  output logic                  MEM_Write,
  output logic                  Fault,
  output logic [1:0]            Fault_Code,
  output logic [31:0]           Instr_Count,
  output logic [15:0]           Wait_Cycles
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FAULT} state_t;

  state_t      state_reg, state_next;
  logic        step_prev_reg;
  logic [7:0]  timer_reg, timer_next;
  logic [3:0]  stage_reg, stage_next;
  logic        done_reg, done_next;
  logic        rd_reg, rd_next;
  logic        wr_reg, wr_next;
  logic [1:0]  code_reg, code_next;
  logic [31:0] count_reg, count_next;
  logic [15:0] waits_reg, waits_next;
  logic        go;
  logic        is_fetch;
  logic        mem_stage;
  logic        timer_last;
  logic        advance;

  assign go         = Run & (~Step_Mode | (Step & ~step_prev_reg));
  assign is_fetch   = (stage_reg == 4'(FETCH_STAGE));
  assign mem_stage  = is_fetch | ((stage_reg == 4'(MEM_STAGE)) & Mem_Req & ~NOP);
  assign timer_last = (timer_reg == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RUN: begin
        if (go && mem_stage) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (MEM_ANA_FLAG)    state_next = S_FAULT;
        else if (MEM_MFC)    state_next = S_RUN;
        else if (timer_last) state_next = S_FAULT;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_RUN;
    endcase
  end

  // Output logic: next values of the registered outputs and counters
  always_comb begin
    stage_next = stage_reg;
    done_next  = 1'b0;
    rd_next    = rd_reg;
    wr_next    = wr_reg;
    code_next  = code_reg;
    timer_next = timer_reg;
    count_next = count_reg;
    waits_next = waits_reg;
    advance    = 1'b0;
    case (state_reg)
      S_RUN: begin
        if (go) begin
          if (mem_stage) begin
            timer_next = 8'd0;
            // Access direction is captured here and held for the whole wait
            if (is_fetch || !Mem_Write_Req) rd_next = 1'b1;
            else                            wr_next = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (MEM_ANA_FLAG) begin
          rd_next   = 1'b0;
          wr_next   = 1'b0;
          code_next = 2'b01;
        end else if (MEM_MFC) begin
          rd_next = 1'b0;
          wr_next = 1'b0;
          advance = 1'b1;
        end else if (timer_last) begin
          rd_next   = 1'b0;
          wr_next   = 1'b0;
          code_next = 2'b10;
        end else begin
          timer_next = timer_reg + 8'd1;
          if (waits_reg != 16'hFFFF) waits_next = waits_reg + 16'd1;
        end
      end
      default: begin
        rd_next = 1'b0;
        wr_next = 1'b0;
      end
    endcase
    if (advance) begin
      done_next = 1'b1;
      if (stage_reg == 4'(NUM_STAGES)) begin
        stage_next = 4'd1;
        count_next = count_reg + 32'd1;
      end else begin
        stage_next = stage_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_prev_reg <= 1'b0;
      timer_reg     <= 8'd0;
      stage_reg     <= 4'd1;
      done_reg      <= 1'b0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      code_reg      <= 2'b00;
      count_reg     <= 32'd0;
      waits_reg     <= 16'd0;
    end else begin
      step_prev_reg <= Step;
      timer_reg     <= timer_next;
      stage_reg     <= stage_next;
      done_reg      <= done_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      code_reg      <= code_next;
      count_reg     <= count_next;
      waits_reg     <= waits_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_onehot
      assign Stage_Onehot[gi] = (stage_reg == 4'(gi + 1));
    end
  endgenerate

  assign Stage       = stage_reg;
  assign Stage_Done  = done_reg;
  assign MEM_Read    = rd_reg;
  assign MEM_Write   = wr_reg;
  assign Fault       = (state_reg == S_FAULT);
  assign Fault_Code  = code_reg;
  assign Instr_Count = count_reg;
  assign Wait_Cycles = waits_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: stimulus pushes expected stage-completion
// and fault events; a negedge monitor pops them when the DUT signals one.
module tb_stage_sequencer;
  localparam int N    = 5;
  localparam int FS   = 1;
  localparam int MS   = 4;
  localparam int TO   = 15;

  logic Clock = 0, Reset = 1, Run = 0, Step_Mode = 0, Step = 0;
  logic Mem_Req = 0, Mem_Write_Req = 0, NOP = 0, MEM_MFC = 0, MEM_ANA_FLAG = 0;
  logic [3:0]   Stage;
  logic [N-1:0] Stage_Onehot;
  logic         Stage_Done, MEM_Read, MEM_Write, Fault;
  logic [1:0]   Fault_Code;
  logic [31:0]  Instr_Count;
  logic [15:0]  Wait_Cycles;

  stage_sequencer #(.NUM_STAGES(N), .FETCH_STAGE(FS), .MEM_STAGE(MS), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Step_Mode(Step_Mode), .Step(Step),
    .Mem_Req(Mem_Req), .Mem_Write_Req(Mem_Write_Req), .NOP(NOP), .MEM_MFC(MEM_MFC),
    .MEM_ANA_FLAG(MEM_ANA_FLAG), .Stage(Stage), .Stage_Onehot(Stage_Onehot),
    .Stage_Done(Stage_Done), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .Fault(Fault),
    .Fault_Code(Fault_Code), .Instr_Count(Instr_Count), .Wait_Cycles(Wait_Cycles)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          is_fault;
    int          stage;
    logic [31:0] count;
    int          waits;
    int          rd;
    int          wr;
    int          code;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural position of the instruction
  int          m_stage = 1;
  logic [31:0] m_count = 0;
  int          m_waits = 0;

  function automatic void check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic int sat_add(int a, int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  function automatic void model_advance(int rd, int wr, int waits_add);
    exp_t e;
    m_waits = sat_add(m_waits, waits_add);
    if (m_stage == N) begin
      m_stage = 1;
      m_count = m_count + 1;
    end else begin
      m_stage = m_stage + 1;
    end
    e = '{is_fault: 1'b0, stage: m_stage, count: m_count, waits: m_waits, rd: rd, wr: wr, code: 0};
    sb.push_back(e);
  endfunction

  function automatic void model_fault(int code, int waits_add, int rd, int wr);
    exp_t e;
    e = '{is_fault: 1'b1, stage: m_stage, count: m_count, waits: sat_add(m_waits, waits_add),
          rd: rd, wr: wr, code: code};
    sb.push_back(e);
  endfunction

  // Monitor: counts strobe cycles per stage and checks each completion/fault event
  int rd_cnt = 0, wr_cnt = 0;
  logic fault_prev = 0;
  always @(negedge Clock) begin
    if (Reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
      fault_prev = 0;
    end else begin
      exp_t e;
      logic [N-1:0] oh;
      oh = '0;
      if (Stage >= 1 && Stage <= N) oh[Stage-1] = 1'b1;
      check("onehot", Stage_Onehot, oh);
      check("strobe_exclusive", MEM_Read & MEM_Write, 0);
      rd_cnt += int'(MEM_Read);
      wr_cnt += int'(MEM_Write);
      if (Stage_Done || (Fault && !fault_prev)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got done=%0d fault=%0d stage=%0d, required none (t=%0t)",
                   Stage_Done, Fault, Stage, $time);
        end else begin
          e = sb.pop_front();
          check("event_is_fault", Fault, e.is_fault);
          check("event_done", Stage_Done, !e.is_fault);
          check("event_stage", Stage, e.stage);
          check("event_instr_count", Instr_Count, e.count);
          check("event_wait_cycles", Wait_Cycles, e.waits);
          check("event_read_cycles", rd_cnt, e.rd);
          check("event_write_cycles", wr_cnt, e.wr);
          check("event_fault_code", Fault_Code, e.code);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      fault_prev = Fault;
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge Clock);
    #3 Reset = 1;
    #1;
    check("rst_stage", Stage, 1);
    check("rst_onehot", Stage_Onehot, 1);
    check("rst_done", Stage_Done, 0);
    check("rst_mem_read", MEM_Read, 0);
    check("rst_mem_write", MEM_Write, 0);
    check("rst_fault", Fault, 0);
    check("rst_fault_code", Fault_Code, 0);
    check("rst_instr_count", Instr_Count, 0);
    check("rst_wait_cycles", Wait_Cycles, 0);
    Run = 0; Step = 0; MEM_MFC = 0; MEM_ANA_FLAG = 0;
    @(posedge Clock);
    #1 Reset = 0;
    check("sb_drained_at_reset", sb.size(), 0);
    sb.delete();
    m_stage = 1;
    m_count = 0;
    m_waits = 0;
  endtask

  // One stage: idle cycles without go, a go cycle, then the wait phase if any
  task automatic do_stage(input bit use_step, input bit mreq, input bit nop, input bit wr,
                          input int idle, input int d);
    bit mem, is_f;
    is_f = (m_stage == FS);
    mem  = is_f || (m_stage == MS && mreq && !nop);
    Mem_Req = mreq; NOP = nop; Mem_Write_Req = wr; MEM_MFC = 0; MEM_ANA_FLAG = 0;
    for (int i = 0; i < idle; i++) begin
      Step = 0;
      Run = 1'($urandom_range(0, 1));
      Step_Mode = Run ? 1'b1 : 1'($urandom_range(0, 1));
      cyc();
    end
    if (mem) model_advance((is_f || !wr) ? d : 0, (!is_f && wr) ? d : 0, d - 1);
    else     model_advance(0, 0, 0);
    Run = 1; Step_Mode = use_step; Step = use_step;
    cyc();
    Run = 0; Step = 0;
    Mem_Req = 1'($urandom_range(0, 1));
    NOP = 1'($urandom_range(0, 1));
    Mem_Write_Req = 1'($urandom_range(0, 1));
    if (mem) begin
      for (int i = 1; i <= d; i++) begin
        MEM_MFC = (i == d);
        cyc();
      end
      MEM_MFC = 0;
    end
  endtask

  task automatic rand_stage();
    do_stage(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(1, 6));
  endtask

  task automatic seek_stage(input int s);
    for (int i = 0; i < N && m_stage != s; i++) rand_stage();
  endtask

  task automatic go_once(input bit mreq, input bit nop, input bit wr);
    Mem_Req = mreq; NOP = nop; Mem_Write_Req = wr; Step_Mode = 0; Step = 0; Run = 1;
    cyc();
    Run = 0;
  endtask

  initial begin
    apply_reset();

    // Free run with MFC tied high: six cycles per instruction, ten instructions in 60
    for (int i = 0; i < 10; i++) begin
      model_advance(1, 0, 0);
      for (int k = 0; k < N - 1; k++) model_advance(0, 0, 0);
    end
    Mem_Req = 0; NOP = 0; MEM_MFC = 1; Step_Mode = 0; Run = 1;
    for (int i = 0; i < 60; i++) cyc();
    Run = 0; MEM_MFC = 0;
    check("freerun_instr_count", Instr_Count, 10);
    check("freerun_stage", Stage, 1);
    cyc();

    for (int i = 0; i < 40; i++) rand_stage();

    // NOP suppresses the data access
    seek_stage(MS);
    do_stage(0, 1, 1, 1, 1, 3);
    // Load with MFC on the fourth wait cycle
    seek_stage(MS);
    do_stage(0, 1, 0, 0, 1, 4);
    check("load_stage_after_mfc", Stage, 5);

    // Step held high 10 cycles, low 3, high again: two advances
    seek_stage(2);
    model_advance(0, 0, 0);
    model_advance(0, 0, 0);
    Mem_Req = 0; Run = 1; Step_Mode = 1; Step = 1;
    for (int i = 0; i < 10; i++) cyc();
    Step = 0;
    for (int i = 0; i < 3; i++) cyc();
    Step = 1;
    for (int i = 0; i < 2; i++) cyc();
    Step = 0; Run = 0;
    cyc();
    check("step_stage", Stage, m_stage);

    for (int i = 0; i < 60; i++) rand_stage();

    // Reset mid-wait between edges
    seek_stage(FS);
    go_once(0, 0, 0);
    cyc();
    check("midwait_read_high", MEM_Read, 1);
    apply_reset();
    for (int i = 0; i < 10; i++) rand_stage();

    // Fetch timeout
    apply_reset();
    for (int i = 0; i < N; i++) rand_stage();
    model_fault(2, TO - 1, TO, 0);
    go_once(0, 0, 0);
    for (int i = 0; i < TO + 3; i++) cyc();
    check("timeout_fault", Fault, 1);
    check("timeout_code", Fault_Code, 2);
    check("timeout_stage", Stage, 1);
    check("timeout_read", MEM_Read, 0);
    Run = 1; MEM_MFC = 1;
    for (int i = 0; i < 5; i++) cyc();
    Run = 0; MEM_MFC = 0;
    check("fault_frozen_stage", Stage, 1);
    check("fault_frozen_count", Instr_Count, m_count);
    check("fault_frozen_waits", Wait_Cycles, sat_add(m_waits, TO - 1));
    apply_reset();

    // Store with ANA and MFC together on the third wait cycle
    seek_stage(MS);
    model_fault(1, 2, 0, 3);
    go_once(1, 0, 1);
    Mem_Write_Req = 0;
    for (int i = 1; i <= 3; i++) begin
      MEM_MFC = (i == 3);
      MEM_ANA_FLAG = (i == 3);
      cyc();
    end
    MEM_MFC = 0; MEM_ANA_FLAG = 0;
    check("ana_code", Fault_Code, 1);
    check("ana_stage", Stage, MS);
    check("ana_write_low", MEM_Write, 0);
    cyc();
    apply_reset();

    cyc();
    check("sb_empty_at_end", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multicycle stage sequencer for the processor core. It steps the instruction through `NUM_STAGES` stages and runs the memory handshake (`MEM_MFC` / `MEM_ANA_FLAG`) in the fetch and memory stages with a wait-state timeout. It supports free-run and single-step modes, and latches faults. It drives the stage number, which the control signal generator decodes into per-stage register enables, plus retire and wait-cycle counters for the display unit.

## Interface
- `NUM_STAGES`, default 5: stages per instruction, 3..15.
- `FETCH_STAGE`, default 1: stage that always performs an instruction read.
- `MEM_STAGE`, default 4: stage that performs a data access when requested; must differ from `FETCH_STAGE`.
- `TIMEOUT`, default 15: maximum wait cycles without MFC before a fault, 1..255.
- `Clock`, in, 1: rising-edge clock.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Run`, in, 1: allows advancing.
- `Step_Mode`, in, 1: 1 means one advance per rising edge of `Step`.
- `Step`, in, 1: level input (switch or key), edge-detected internally.
- `Mem_Req`, in, 1: the current instruction accesses data memory in `MEM_STAGE`.
- `Mem_Write_Req`, in, 1: the `MEM_STAGE` access is a write (0 means read).
- `NOP`, in, 1: the current instruction is a no-operation; suppresses the `MEM_STAGE` access.
- `MEM_MFC`, in, 1: memory function complete.
- `MEM_ANA_FLAG`, in, 1: address not assigned.
- `Stage`, out, 4: current stage, 1..`NUM_STAGES`.
- `Stage_Onehot`, out, `NUM_STAGES`: bit `Stage-1` set.
- `Stage_Done`, out, 1: one-cycle pulse in the first cycle of each new stage.
- `MEM_Read`, out, 1; `MEM_Write`, out, 1: memory strobes, both registered.
- `Fault`, out, 1: sticky fault.
- `Fault_Code`, out, 2: 01 = ANA, 10 = timeout, 00 = none.
- `Instr_Count`, out, 32: retired instructions; wraps modulo 2^32.
- `Wait_Cycles`, out, 16: total memory wait cycles; saturates at 16'hFFFF.

## Operation
- Reset values:
  - `Stage`=1 and `Stage_Onehot`=1.
  - `Stage_Done`, `MEM_Read`, `MEM_Write`, `Fault` = 0.
  - `Fault_Code`=00, and both counters = 0.
  - State=RUN, internal `Step` history=0, wait timer=0.
- `go` = `Run` & (!`Step_Mode` | (`Step` & !step_prev)). A `Step` already high at reset release counts as one edge.
- A stage is a memory stage when it is `FETCH_STAGE`, or when it is `MEM_STAGE` with `Mem_Req`=1 and `NOP`=0.
- RUN, non-memory stage:
  - On `go`: `Stage` advances at the next edge and `Stage_Done` pulses.
  - With no `go`: hold.
- RUN, memory stage:
  - On `go`: enter WAIT, timer=0, and assert the strobe from the next edge.
  - The strobe is `MEM_Read` for fetch, or `MEM_Write`/`MEM_Read` per `Mem_Write_Req` for `MEM_STAGE`.
  - `Mem_Write_Req`, `Mem_Req` and `NOP` are sampled only at WAIT entry.
- WAIT, evaluated in priority order:
  1. `MEM_ANA_FLAG`=1: go to FAULT with code 01.
  2. `MEM_MFC`=1: drop the strobe, advance `Stage`, pulse `Stage_Done`, return to RUN.
  3. Timer = `TIMEOUT`-1: go to FAULT with code 10.
  4. Otherwise: timer+1 and `Wait_Cycles`+1 (saturating).
- `Run` and `Step` are ignored in WAIT. An access in flight always completes or faults.
- Advancing from stage `NUM_STAGES`: `Stage` goes to 1 and `Instr_Count`+1 on the same edge.
- FAULT: `Stage` frozen, strobes 0, counters frozen. Only `Reset` exits.
- `MEM_Read` and `MEM_Write` are never high together.

## Timing
- Non-memory stage: `go` in cycle n gives the new `Stage` and `Stage_Done`=1 in cycle n+1.
- Memory stage: `go` in cycle n gives the strobe high from cycle n+1. `MEM_MFC` sampled high in cycle m gives the strobe low and the new `Stage` in cycle m+1.
- Minimum memory stage is 2 cycles, so the free-run minimum is `NUM_STAGES`+1 cycles per instruction without a data access and `NUM_STAGES`+2 cycles with one.
- Timeout: with no MFC, `Fault` rises after exactly `TIMEOUT` cycles of strobe high, and the strobe falls on the same edge.
- Reset asserted at any time, including mid-WAIT, forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Free-run with default parameters, `MEM_MFC` tied 1, `Mem_Req`=0: `Stage` sequence is 1,1,2,3,4,5,1…; `Instr_Count`=10 at cycle 60; `MEM_Write` is never 1.
- Load (`Mem_Req`=1, `Mem_Write_Req`=0) with MFC arriving on the 4th wait cycle:
  - `MEM_Read` is high for 4 cycles during stage 4.
  - `Wait_Cycles` increases by 3.
  - `Stage`=5 the cycle after MFC.
- MFC never arrives in fetch, `TIMEOUT`=15:
  - `MEM_Read` is high for exactly 15 cycles.
  - Then `Fault`=1, `Fault_Code`=10, `Stage` stays 1, and `Instr_Count` is frozen.
- Store in stage 4 with `MEM_ANA_FLAG` and `MEM_MFC` high in the same cycle: `Fault_Code`=01, `Stage` stays 4, `MEM_Write` goes low next cycle.
- `Step_Mode`=1, `Step` held high for 10 cycles, then low for 3, then high: exactly two advances; `NOP`=1 with `Mem_Req`=1 makes stage 4 advance with no strobe.
- `Reset` pulsed mid-WAIT between clock edges: `MEM_Read`=0 and `Stage`=1 before the next edge; normal fetch resumes after release.
